// File: rtl/tlb_pkg.sv
// Shared definitions for the Sv32 page-table walker and TLB refill path.
//   - PTE bit positions (flags and PPN field)
//   - CAM entry field positions: {VPN[51:32], PPN[31:10], RSW[9:8], flags[7:0]}
//   - walker FSM state enum and PTE classification enum
package tlb_pkg;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_U       = 4;
  localparam int PTE_G       = 5;
  localparam int PTE_A       = 6;
  localparam int PTE_D       = 7;
  localparam int PTE_PPN_LSB = 10;
  localparam int PTE_PPN_MSB = 31;

  localparam int ENT_W         = 52;
  localparam int ENT_VPN_MSB   = 51;
  localparam int ENT_VPN_LSB   = 32;
  localparam int ENT_PPN_MSB   = 31;
  localparam int ENT_PPN_LSB   = 10;
  localparam int ENT_RSW_MSB   = 9;
  localparam int ENT_FLAGS_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WALK1  = 3'd1,
    ST_WALK0  = 3'd2,
    ST_REFILL = 3'd3,
    ST_FAULT  = 3'd4
  } ptw_state_e;

  typedef enum logic [1:0] {
    PTE_IS_FAULT = 2'd0,
    PTE_IS_LEAF  = 2'd1,
    PTE_IS_PTR   = 2'd2
  } pte_class_e;

endpackage

// File: rtl/tlb_pte_check.sv
// Combinational Sv32 PTE classifier.
//   pte       in  32  PTE as returned by memory
//   level1    in  1   1 = PTE fetched at level 1, 0 = level 0
//   pte_class out     leaf, pointer or fault
// Optional macro TLB_PTW_SUPERPAGE_EN: level-1 leaves with a zero low PPN
// slice are accepted as megapages; without it every level-1 leaf faults.
module tlb_pte_check
  import tlb_pkg::*;
(
  input  logic [31:0] pte,
  input  logic        level1,
  output pte_class_e  pte_class
);

  logic unused_pte;

  always_comb begin
    pte_class = PTE_IS_FAULT;
    if (!pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W])) begin
      pte_class = PTE_IS_FAULT;
    end else if (pte[PTE_R] || pte[PTE_X]) begin
      if (!pte[PTE_A]) begin
        pte_class = PTE_IS_FAULT;
      end else if (!level1) begin
        pte_class = PTE_IS_LEAF;
      end else begin
`ifdef TLB_PTW_SUPERPAGE_EN
        // Megapage must be 4 MiB aligned: PPN[0] slice has to be zero.
        pte_class = (pte[19:10] == 10'd0) ? PTE_IS_LEAF : PTE_IS_FAULT;
`else
        pte_class = PTE_IS_FAULT;
`endif
      end
    end else if (level1) begin
      pte_class = PTE_IS_PTR;
    end else begin
      pte_class = PTE_IS_FAULT;
    end
  end

  // Address and software bits play no part in classification.
`ifdef TLB_PTW_SUPERPAGE_EN
  assign unused_pte = ^{pte[PTE_PPN_MSB:20], pte[9:8], pte[PTE_D], pte[PTE_G], pte[PTE_U]};
`else
  assign unused_pte = ^{pte[PTE_PPN_MSB:PTE_PPN_LSB], pte[9:8], pte[PTE_D], pte[PTE_G], pte[PTE_U]};
`endif

endmodule

// File: rtl/tlb_refill_ptw.sv
// Sv32 hardware page-table walker and TLB refill engine.
// A miss pulse starts a walk of up to two PTE reads; the walk ends with a
// one-cycle CAM write (REFILL) or a one-cycle page fault (FAULT).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   miss_valid, miss_vpn   walk request (accepted only when idle)
//   satp_ppn               root table PPN, captured when the walk is accepted
//   mem_req/addr/ack/rdata PTE read port; addr held until ack
//   we/write_addr/data     CAM write port, victim chosen round-robin
//   done, page_fault, busy walk status
// Optional macro TLB_PTW_SUPERPAGE_EN (see tlb_pte_check) enables megapage refill.
module tlb_refill_ptw
  import tlb_pkg::*;
#(
  parameter int TLB_WIDTH  = 52,
  parameter int TLB_HEIGHT = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_valid,
  input  logic [19:0]                   miss_vpn,
  input  logic [21:0]                   satp_ppn,
  output logic                          mem_req,
  output logic [33:0]                   mem_addr,
  input  logic                          mem_ack,
  input  logic [31:0]                   mem_rdata,
  output logic                          we,
  output logic [$clog2(TLB_HEIGHT)-1:0] write_addr,
  output logic [TLB_WIDTH-1:0]          write_data,
  output logic                          done,
  output logic                          page_fault,
  output logic                          busy
);

  localparam int VIC_W = $clog2(TLB_HEIGHT);

  ptw_state_e           state_q, state_d;
  logic [19:0]          vpn_q;
  logic [33:0]          mem_addr_q;
  logic [TLB_WIDTH-1:0] wdata_q;
  logic [VIC_W-1:0]     victim_q;

  pte_class_e  pte_class;
  logic        level1;
  logic [21:0] leaf_ppn;
  logic [ENT_W-1:0] entry;

  assign level1 = (state_q == ST_WALK1);

  tlb_pte_check u_pte_check (
    .pte       (mem_rdata),
    .level1    (level1),
    .pte_class (pte_class)
  );

  // A level-1 leaf maps 4 MiB; it is refilled as the 4 KiB page the miss hit.
  assign leaf_ppn = level1 ? {mem_rdata[31:20], vpn_q[9:0]} : mem_rdata[PTE_PPN_MSB:PTE_PPN_LSB];

  always_comb begin
    entry = '0;
    entry[ENT_VPN_MSB:ENT_VPN_LSB]   = vpn_q;
    entry[ENT_PPN_MSB:ENT_PPN_LSB]   = leaf_ppn;
    entry[ENT_RSW_MSB:ENT_FLAGS_LSB] = mem_rdata[9:0];
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    we         = 1'b0;
    done       = 1'b0;
    page_fault = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (miss_valid) state_d = ST_WALK1;
      end
      ST_WALK1: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          case (pte_class)
            PTE_IS_LEAF: state_d = ST_REFILL;
            PTE_IS_PTR:  state_d = ST_WALK0;
            default:     state_d = ST_FAULT;
          endcase
        end
      end
      ST_WALK0: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = (pte_class == PTE_IS_LEAF) ? ST_REFILL : ST_FAULT;
      end
      ST_REFILL: begin
        we      = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        done       = 1'b1;
        page_fault = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      victim_q   <= '0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (miss_valid) mem_addr_q <= {satp_ppn, miss_vpn[19:10], 2'b00};
        end
        ST_WALK1: begin
          if (mem_ack && pte_class == PTE_IS_PTR)
            mem_addr_q <= {mem_rdata[PTE_PPN_MSB:PTE_PPN_LSB], vpn_q[9:0], 2'b00};
        end
        ST_REFILL: begin
          victim_q <= (victim_q == VIC_W'(TLB_HEIGHT - 1)) ? '0 : victim_q + 1'b1;
        end
        default: ;
      endcase
      if ((state_q == ST_WALK1 || state_q == ST_WALK0) && mem_ack && pte_class == PTE_IS_LEAF)
        wdata_q <= TLB_WIDTH'(entry);
    end
  end

  // VPN is pure data; it is only consumed after being loaded on acceptance.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && miss_valid) vpn_q <= miss_vpn;
  end

  assign mem_addr   = mem_addr_q;
  assign write_addr = victim_q;
  assign write_data = wdata_q;

endmodule

// File: doc/tlb_refill_ptw.md
# tlb_refill_ptw

Sv32 hardware page-table walker and refill engine for the 32-entry TLB CAM. A TLB miss starts a walk: the block fetches up to two PTEs over a simple memory request/acknowledge port, checks them, and writes a 52-bit entry into the CAM through its write port. The walk ends in either a refill or a page fault. Victim slots are chosen round-robin. The block sits between the CAM's miss output and the data-side memory arbiter.

## Interface
Parameters:
- TLB_WIDTH, 52, CAM entry width: {VPN[51:32], PPN[31:10], RSW[9:8], flags[7:0]}
- TLB_HEIGHT, 32, CAM entries; victim pointer width is log2(TLB_HEIGHT)

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  synchronous, active-high reset.
- miss_valid  in  1  one-cycle pulse requesting a walk. It is sampled only in IDLE.
- miss_vpn  in  20  faulting VPN. Latched together with miss_valid.
- satp_ppn  in  22  root page-table PPN. Sampled when the L1 address is formed.
- mem_req  out  1  PTE read request.
- mem_addr  out  34  physical PTE address. Word aligned, so bits [1:0] are 0.
- mem_ack  in  1  read complete. mem_rdata is valid in the same cycle.
- mem_rdata  in  32  PTE.
- we  out  1  CAM write strobe.
- write_addr  out  5  CAM victim index.
- write_data  out  52  CAM entry.
- done  out  1  walk finished. Pulses for one cycle.
- page_fault  out  1  walk faulted. Pulses for one cycle, coincident with done.
- busy  out  1  high in every state except IDLE.

## Operation
States: IDLE, WALK1, WALK0, REFILL, FAULT.
- **IDLE:**
  - On miss_valid, latch vpn and go to WALK1.
  - miss_valid asserted in any other state is dropped.
- **WALK1:**
  - mem_req=1.
  - mem_addr={satp_ppn, vpn[19:10], 2'b00}.
  - On mem_ack the PTE is checked and the next state is chosen (see PTE checks below).
- **WALK0:**
  - mem_req=1.
  - mem_addr={pte1.PPN, vpn[9:0], 2'b00}.
  - On mem_ack the PTE is checked.
  - A valid leaf goes to REFILL. Anything else goes to FAULT.
- **REFILL:**
  - we=1, done=1 for one cycle.
  - write_addr=victim.
  - write_data={vpn, ppn, pte[9:0]}.
  - victim increments modulo 32 (31 wraps to 0).
  - Next state is IDLE.
- **FAULT:**
  - page_fault=1, done=1 for one cycle.
  - we=0 and victim is unchanged.
  - Next state is IDLE.

PTE checks, applied in this order:
1. Fault if V=0, or if R=0 and W=1.
2. A PTE with R|X set is a leaf.
   - A leaf with A=0 faults.
   - A leaf at level 1 is handled as a megapage (see Configuration).
3. A PTE with R=X=0 is a pointer.
   - A pointer at level 1 goes to WALK0.
   - A pointer at level 0 faults.

PPN written to the CAM:
- Level-0 leaf: pte[31:10].
- Megapage: {pte[31:20], vpn[9:0]}.

## Timing
- Reset values:
  - state=IDLE, victim=0.
  - mem_req, we, done, page_fault and busy are 0.
  - mem_addr, write_addr and write_data are 0.
  - Outputs are registered or decoded from the registered state.
- Reset asserted mid-walk forces IDLE on the next edge.
  - mem_req drops.
  - Any ack that arrives afterwards is ignored.
  - victim returns to 0.
- Memory handshake:
  - mem_req and mem_addr stay stable until mem_ack.
  - One ack completes one request.
  - On the WALK1 to WALK0 transition, mem_req stays high and mem_addr changes on the next cycle. That cycle starts a new request.
- Latency, with miss_valid at cycle 0 and zero-wait-state memory (ack in the first request cycle):
  - mem_req high at cycle 1.
  - Two-level refill: we/done at cycle 3.
  - Megapage refill or L1 fault: done at cycle 2.
- Each extra memory wait cycle adds exactly one cycle.
- When the CAM sees we=1, it updates its entry on the same edge on which this block leaves REFILL.

## Configuration
- TLB_PTW_SUPERPAGE_EN defined:
  - A level-1 leaf whose pte[19:10] is 0 is refilled as a synthesized 4 KiB entry.
  - A level-1 leaf whose pte[19:10] is nonzero faults as a misaligned megapage.
- TLB_PTW_SUPERPAGE_EN undefined: every level-1 leaf faults.

## Structure
- Shared package tlb_pkg holds:
  - PTE bit-position constants: V=0, R=1, W=2, X=3, U=4, G=5, A=6, D=7, PPN at [31:10].
  - The CAM entry field positions.
  - The walker state enum.
- One sub-module, tlb_pte_check: combinational classification of a PTE plus level into leaf, pointer or fault.
- The FSM, address formation and victim counter live in the top module.

## Test plan
- **Two-level refill.** satp_ppn=0x00100, vpn=0x12345.
  - Expect mem_addr=0x100120; ack with rdata=0x00080001.
  - Expect mem_addr=0x200D14; ack with rdata=0x002AF0D7.
  - Required: we=1, write_addr=0, write_data=0x12345002AF0D7, page_fault=0.
- **Megapage.** Same vpn; L1 ack with 0x001000CF.
  - With the macro: write_data=0x12345001D14CF, one memory access.
  - Without the macro: page_fault=1, we=0.
- **Misaligned megapage and level-0 faults**, each giving page_fault=1 with we=0 and victim unchanged:
  - L1 leaf 0x001004CF.
  - L0 PTE 0x00000000 (V=0).
  - L0 pointer 0x00080001.
  - L0 leaf with A=0 (0x002AF097).
- **Victim wrap.** 33 consecutive successful refills.
  - Required: write_addr runs 0..31 then 0.
  - A miss_valid pulse during busy produces no extra walk.
- **Reset mid-walk.** Raise rst while in WALK0 with mem_ack held low.
  - Required: mem_req=0 and busy=0 on the next cycle.
  - A late mem_ack pulse causes no we.
- **Wait states.** Hold mem_ack low for 3 cycles per access.
  - Required: mem_addr stable throughout each access.
  - Required: done at cycle 9.
